wb_stage_p: RTL and testbench

Parametrised write-back stage for the 5-stage pipeline. Registers one retiring instruction per cycle and selects its result from ALU, memory, link or immediate sources. Extracts and sign/zero-extends sub-word load data. Drives the register-file write port with a valid/ready handshake, and exposes a forwarding tap and a retired-instruction counter.

---
 rtl/wb_stage_p_pkg.sv | 22 ++
 rtl/wb_stage_p_load_align.sv | 35 +++
 rtl/wb_stage_p.sv | 104 ++++++++++
 tb/tb_wb_stage_p.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_p_pkg.sv
// Shared pipeline encodings for the write-back stage: result sources and load sizes.
package wb_stage_p_pkg;

   typedef enum logic [1:0] {
      SRC_ALU  = 2'd0,
      SRC_MEM  = 2'd1,
      SRC_LINK = 2'd2,
      SRC_IMM  = 2'd3
   } src_e;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2,
      SZ_D = 2'd3
   } size_e;

   function automatic int size_bits(input logic [1:0] size);
      return 8 << size;
   endfunction

endpackage

// File: rtl/wb_stage_p_load_align.sv
// Combinational sub-word load extraction: shift by byte offset, keep 8/16/32/64 bits, extend.
module load_align
   import wb_stage_p_pkg::*;
#(
   parameter  int DATA_W = 64,
   localparam int OFF_W  = $clog2(DATA_W/8)
) (
   input  logic [DATA_W-1:0] mem,
   input  logic [1:0]        size,
   input  logic              sign_ext,
   input  logic [OFF_W-1:0]  off,
   output logic [DATA_W-1:0] result
);

   logic [DATA_W-1:0] shifted;
   logic [DATA_W-1:0] mask;
   logic [DATA_W-1:0] msb;
   int                nbits;

   // A size wider than the datapath keeps the whole shifted word.
   always_comb begin
      shifted = mem >> {off, 3'b000};
      nbits   = size_bits(size);
      mask    = '1;
      if (nbits < DATA_W) begin
         mask = ~({DATA_W{1'b1}} << nbits);
      end
      msb    = mask ^ (mask >> 1);
      result = shifted & mask;
      if (sign_ext && |(shifted & msb)) begin
         result = result | ~mask;
      end
   end

endmodule

// File: rtl/wb_stage_p.sv
// Write-back stage: result select, one-entry holding register, register-file handshake,
// forwarding tap and retire counter.
module wb_stage_p
   import wb_stage_p_pkg::*;
#(
   parameter  int DATA_W   = 64,
   parameter  int REG_AW   = 6,
   parameter  int CNT_W    = 32,
   parameter  int ZERO_REG = 1,
   localparam int OFF_W    = $clog2(DATA_W/8)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_sel,
   input  logic [DATA_W-1:0] in_alu,
   input  logic [DATA_W-1:0] in_mem,
   input  logic [DATA_W-1:0] in_link,
   input  logic [DATA_W-1:0] in_imm,
   input  logic [1:0]        in_size,
   input  logic              in_signed,
   input  logic [OFF_W-1:0]  in_off,
   input  logic              in_regwr,
   input  logic [REG_AW-1:0] in_rd,
   input  logic              flush,
   output logic              rf_wr_en,
   input  logic              rf_ready,
   output logic [REG_AW-1:0] rf_wr_addr,
   output logic [DATA_W-1:0] rf_wr_data,
   output logic              fwd_valid,
   output logic [REG_AW-1:0] fwd_rd,
   output logic [DATA_W-1:0] fwd_data,
   output logic [CNT_W-1:0]  retire_cnt
);

   logic              valid_q;
   logic              regwr_q;
   logic [REG_AW-1:0] rd_q;
   logic [DATA_W-1:0] data_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] mem_data;
   logic [DATA_W-1:0] result;
   logic              regwr_d;
   logic              leaving;
   logic              accept;

   load_align #(.DATA_W(DATA_W)) u_load_align (
      .mem      (in_mem),
      .size     (in_size),
      .sign_ext (in_signed),
      .off      (in_off),
      .result   (mem_data)
   );

   always_comb begin
      result = in_alu;
      case (src_e'(in_sel))
         SRC_ALU:  result = in_alu;
         SRC_MEM:  result = mem_data;
         SRC_LINK: result = in_link;
         SRC_IMM:  result = in_imm;
         default:  result = in_alu;
      endcase
   end

   assign regwr_d = in_regwr & ~((ZERO_REG != 0) && (in_rd == '0));

   // Non-writing entries drain unconditionally one cycle after acceptance.
   assign rf_wr_en = valid_q & regwr_q & ~flush;
   assign leaving  = valid_q & (~regwr_q | (rf_ready & ~flush));
   assign in_ready = ~flush & (~valid_q | leaving);
   assign accept   = in_valid & in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         regwr_q <= 1'b0;
         rd_q    <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
      end else begin
         if (flush) begin
            valid_q <= 1'b0;
         end else if (accept) begin
            valid_q <= 1'b1;
            regwr_q <= regwr_d;
            rd_q    <= in_rd;
            data_q  <= result;
            cnt_q   <= cnt_q + 1'b1;
         end else if (leaving) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign rf_wr_addr = rd_q;
   assign rf_wr_data = data_q;
   assign fwd_valid  = valid_q & regwr_q;
   assign fwd_rd     = rd_q;
   assign fwd_data   = data_q;
   assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_wb_stage_p.sv
// Randomised and directed checks of wb_stage_p against a queue-based occupancy/result model.
module tb_wb_stage_p;

   localparam int DATA_W = 64;
   localparam int REG_AW = 6;
   localparam int CNT_W  = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [1:0]        in_sel;
   logic [DATA_W-1:0] in_alu, in_mem, in_link, in_imm;
   logic [1:0]        in_size;
   logic              in_signed;
   logic [2:0]        in_off;
   logic              in_regwr;
   logic [REG_AW-1:0] in_rd;
   logic              flush;
   logic              rf_wr_en;
   logic              rf_ready;
   logic [REG_AW-1:0] rf_wr_addr;
   logic [DATA_W-1:0] rf_wr_data;
   logic              fwd_valid;
   logic [REG_AW-1:0] fwd_rd;
   logic [DATA_W-1:0] fwd_data;
   logic [CNT_W-1:0]  retire_cnt;

   wb_stage_p #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W), .ZERO_REG(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
      .in_alu(in_alu), .in_mem(in_mem), .in_link(in_link), .in_imm(in_imm),
      .in_size(in_size), .in_signed(in_signed), .in_off(in_off), .in_regwr(in_regwr),
      .in_rd(in_rd), .flush(flush), .rf_wr_en(rf_wr_en), .rf_ready(rf_ready),
      .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data), .fwd_valid(fwd_valid),
      .fwd_rd(fwd_rd), .fwd_data(fwd_data), .retire_cnt(retire_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic              regwr;
      logic [REG_AW-1:0] rd;
      logic [DATA_W-1:0] data;
   } ent_t;

   ent_t              held[$];
   logic [REG_AW-1:0] commits[$];
   int                mcnt;
   int                total;
   int                bad;
   logic              last_acc;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] ref_result(input logic [1:0] sel, input logic [63:0] alu,
         input logic [63:0] mem, input logic [63:0] link, input logic [63:0] imm,
         input logic [1:0] size, input logic sgn, input logic [2:0] off);
      int          widths[4] = '{8, 16, 32, 64};
      int          nbits;
      logic [63:0] shifted, lo, span;
      case (sel)
         2'd0: return alu;
         2'd2: return link;
         2'd3: return imm;
         default: begin
            nbits   = widths[size];
            shifted = mem >> (8 * int'(off));
            if (nbits == 64) return shifted;
            span = 64'd1 << nbits;
            lo   = shifted % span;
            if (sgn && lo >= (span / 2)) lo = lo - span;
            return lo;
         end
      endcase
   endfunction

   // Checks outputs at the falling edge, then advances the model across the next rising edge.
   task automatic step();
      logic held_v, wr, leave, exp_rdy;
      ent_t e;
      @(negedge clk);
      held_v = (held.size() > 0);
      wr     = held_v && held[0].regwr;
      chk("rf_wr_en", 64'(rf_wr_en), 64'(wr && !flush));
      chk("fwd_valid", 64'(fwd_valid), 64'(wr));
      if (wr) begin
         chk("rf_wr_addr", 64'(rf_wr_addr), 64'(held[0].rd));
         chk("rf_wr_data", rf_wr_data, held[0].data);
         chk("fwd_rd", 64'(fwd_rd), 64'(held[0].rd));
         chk("fwd_data", fwd_data, held[0].data);
      end
      leave   = held_v && (!held[0].regwr || (rf_ready && !flush));
      exp_rdy = !flush && (!held_v || leave);
      chk("in_ready", 64'(in_ready), 64'(exp_rdy));
      chk("retire_cnt", 64'(retire_cnt), 64'(mcnt));
      if (rf_wr_en && rf_ready) commits.push_back(rf_wr_addr);
      last_acc = 1'b0;
      if (flush) begin
         held.delete();
      end else begin
         if (leave) void'(held.pop_front());
         if (in_valid && exp_rdy) begin
            e.regwr = in_regwr && (in_rd != 0);
            e.rd    = in_rd;
            e.data  = ref_result(in_sel, in_alu, in_mem, in_link, in_imm, in_size, in_signed, in_off);
            held.push_back(e);
            mcnt     = (mcnt + 1) % 16;
            last_acc = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_alu(input logic [REG_AW-1:0] rd, input logic [63:0] val);
      in_valid = 1'b1; in_sel = 2'd0; in_alu = val; in_regwr = 1'b1; in_rd = rd;
   endtask

   task automatic set_load(input logic [2:0] off, input logic [1:0] size, input logic sgn);
      in_valid = 1'b1; in_sel = 2'd1; in_mem = 64'h00000000_8000F0AA; in_off = off;
      in_size = size; in_signed = sgn; in_regwr = 1'b1; in_rd = 6'd7;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_wr_en"}, 64'(rf_wr_en), 64'd0);
      chk({tag, "_fwd_v"}, 64'(fwd_valid), 64'd0);
      chk({tag, "_fwd_rd"}, 64'(fwd_rd), 64'd0);
      chk({tag, "_fwd_d"}, fwd_data, 64'd0);
      chk({tag, "_addr"}, 64'(rf_wr_addr), 64'd0);
      chk({tag, "_data"}, rf_wr_data, 64'd0);
      chk({tag, "_cnt"}, 64'(retire_cnt), 64'd0);
   endtask

   initial begin
      int c, k, saved_cnt, saved_commits;
      total = 0; bad = 0; mcnt = 0;
      rst_n = 1'b0; in_valid = 1'b0; in_sel = 2'd0; in_alu = '0; in_mem = '0; in_link = '0;
      in_imm = '0; in_size = 2'd0; in_signed = 1'b0; in_off = 3'd0; in_regwr = 1'b0;
      in_rd = '0; flush = 1'b0; rf_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst_n = 1'b1;
      #1;
      chk("ready_after_reset", 64'(in_ready), 64'd1);

      // sub-word load extraction
      set_load(3'd1, 2'd0, 1'b1); step();
      chk("ld_b_signed", rf_wr_data, 64'hFFFFFFFF_FFFFFFF0);
      set_load(3'd1, 2'd0, 1'b0); step();
      chk("ld_b_unsigned", rf_wr_data, 64'h00000000_000000F0);
      set_load(3'd2, 2'd1, 1'b1); step();
      chk("ld_h_signed", rf_wr_data, 64'hFFFFFFFF_FFFF8000);
      in_valid = 1'b0; step();

      // back-to-back ALU writes with a two-cycle register-file stall
      commits.delete();
      saved_cnt = mcnt;
      k = 0;
      for (c = 0; c < 30 && commits.size() < 4; c++) begin
         if (k < 4) set_alu(6'(k + 1), 64'(100 + k));
         else in_valid = 1'b0;
         rf_ready = !(c == 2 || c == 3);
         step();
         if (last_acc) k++;
      end
      chk("stall_commits", 64'(commits.size()), 64'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < commits.size()) chk("stall_order", 64'(commits[i]), 64'(i + 1));
      end
      chk("stall_cnt", 64'(retire_cnt), 64'((saved_cnt + 4) % 16));
      in_valid = 1'b0; rf_ready = 1'b1; step();

      // register 0 is never written but still retires
      saved_cnt = mcnt;
      set_alu(6'd0, 64'hDEAD); step();
      chk("zreg_wr_en", 64'(rf_wr_en), 64'd0);
      chk("zreg_fwd", 64'(fwd_valid), 64'd0);
      chk("zreg_cnt", 64'(retire_cnt), 64'((saved_cnt + 1) % 16));
      in_valid = 1'b0; step();

      // flush over a stalled entry drops it and blocks acceptance
      rf_ready = 1'b0;
      set_alu(6'd5, 64'h55); step();
      saved_cnt = mcnt; saved_commits = commits.size();
      set_alu(6'd6, 64'h66); flush = 1'b1;
      #1;
      chk("flush_ready", 64'(in_ready), 64'd0);
      step();
      flush = 1'b0; in_valid = 1'b0; rf_ready = 1'b1;
      step();
      chk("flush_cnt", 64'(retire_cnt), 64'(saved_cnt));
      chk("flush_no_write", 64'(commits.size()), 64'(saved_commits));

      // asynchronous reset with a held entry
      rf_ready = 1'b0;
      set_alu(6'd9, 64'h99); step();
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check_all_zero("midreset");
      held.delete(); mcnt = 0;
      @(posedge clk); #1;
      chk("midreset_hold", 64'(rf_wr_en), 64'd0);
      rst_n = 1'b1; rf_ready = 1'b1;
      step();

      // 17 retirements wrap a 4-bit counter to 1
      for (c = 0; c < 17; c++) begin
         set_alu(6'(c % 8 + 1), 64'(c));
         step();
      end
      chk("wrap_cnt", 64'(retire_cnt), 64'd1);
      in_valid = 1'b0; step();

      // randomised traffic
      for (c = 0; c < 400; c++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         in_sel    = 2'($urandom_range(0, 3));
         in_alu    = {$urandom, $urandom};
         in_mem    = {$urandom, $urandom};
         in_link   = {$urandom, $urandom};
         in_imm    = {$urandom, $urandom};
         in_size   = 2'($urandom_range(0, 3));
         in_signed = 1'($urandom_range(0, 1));
         in_off    = 3'($urandom_range(0, 7));
         in_regwr  = ($urandom_range(0, 9) < 8);
         in_rd     = 6'($urandom_range(0, 7));
         rf_ready  = ($urandom_range(0, 9) < 6);
         flush     = ($urandom_range(0, 9) == 0);
         step();
      end
      flush = 1'b0; in_valid = 1'b0; rf_ready = 1'b1;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
